// File: rtl/adc_sample_pacer_if.sv
// Register-bus bundle for adc_sample_pacer: address/data/strobes plus combinational read data.
interface adc_sample_pacer_if;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic        write;
  logic        read;
  logic [31:0] Rdata;

  modport master (output addr, output Wdata, output write, output read, input Rdata);
  modport slave  (input addr, input Wdata, input write, input read, output Rdata);
endinterface

// File: rtl/adc_sample_pacer.sv
// Bus-loaded sample FIFO replayed onto ADC/pushADC at a programmable cycle interval,
// feeding every correlator channel with a repeatable paced stream.
module adc_sample_pacer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  adc_sample_pacer_if.slave   bus,
  output logic [15:0]         ADC,
  output logic                pushADC,
  output logic [AW:0]         level
);

  localparam logic [15:0] SAMPLE_ADDR = 16'h0120;
  localparam logic [15:0] PACE_ADDR   = 16'h0124;
  localparam logic [15:0] CTRL_ADDR   = 16'h0128;
  localparam logic [15:0] STATUS_ADDR = 16'h012C;
  localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   pace;
  logic [31:0]   cnt;
  logic [31:0]   reload;
  logic          enable;
  logic          ovf;
  logic          udf;

  logic [15:0]   reg_addr;
  logic          wr_sample;
  logic          wr_pace;
  logic          wr_ctrl;
  logic          rd_status;
  logic          flush;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_event;
  logic          udf_event;
  logic [7:0]    level_byte;
  logic          unused_addr_bits;

  assign reg_addr         = bus.addr[15:0];
  assign unused_addr_bits = ^bus.addr[31:16];

  assign wr_sample = bus.write && (reg_addr == SAMPLE_ADDR);
  assign wr_pace   = bus.write && (reg_addr == PACE_ADDR);
  assign wr_ctrl   = bus.write && (reg_addr == CTRL_ADDR);
  assign rd_status = bus.read  && (reg_addr == STATUS_ADDR);
  assign flush     = wr_ctrl && bus.Wdata[1];

  assign empty  = (level == '0);
  assign full   = (level == FULL_LEVEL);
  assign reload = (pace == '0) ? '0 : pace - 32'd1;

  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign pop       = enable && (cnt == '0) && !empty;
  assign push_ok   = wr_sample && !flush && (!full || pop);
  assign ovf_event = wr_sample && !flush && full && !pop;
  assign udf_event = enable && (cnt == '0) && empty;

  assign level_byte = 8'(level);

  always_comb begin
    bus.Rdata = '0;
    if (bus.read) begin
      case (reg_addr)
        PACE_ADDR:   bus.Rdata = pace;
        CTRL_ADDR:   bus.Rdata = {31'b0, enable};
        STATUS_ADDR: bus.Rdata = {16'b0, level_byte, 4'b0, udf, ovf, full, empty};
        default:     bus.Rdata = '0;
      endcase
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= bus.Wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      pace    <= 32'd1;
      enable  <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      cnt     <= '0;
      ADC     <= '0;
      pushADC <= 1'b0;
    end else begin
      pushADC <= pop && !flush;
      if (pop && !flush) begin
        ADC <= mem[rptr];
      end

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
        cnt   <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (!enable)          cnt <= '0;
        else if (cnt != '0)   cnt <= cnt - 32'd1;
        else if (pop)         cnt <= reload;
      end

      // Set wins over the clear-on-read of STATUS.
      ovf <= ovf_event || (ovf && !rd_status);
      udf <= udf_event || (udf && !rd_status);

      if (wr_pace) pace   <= bus.Wdata;
      if (wr_ctrl) enable <= bus.Wdata[0];
    end
  end

endmodule

// File: tb/tb_adc_sample_pacer.sv
// Self-checking bench for adc_sample_pacer: register table, directed corner sequences,
// and randomized bus traffic compared against a queue/timestamp reference model.
module tb_adc_sample_pacer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [31:0] A_SAMPLE = 32'h0120;
  localparam logic [31:0] A_PACE   = 32'h0124;
  localparam logic [31:0] A_CTRL   = 32'h0128;
  localparam logic [31:0] A_STATUS = 32'h012C;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] ADC;
  logic pushADC;
  logic [AW:0] level;

  always #5 clk = ~clk;

  adc_sample_pacer_if bus();

  adc_sample_pacer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ADC(ADC), .pushADC(pushADC), .level(level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sample queue plus the cycle index at which the next pop is allowed.
  logic [15:0] q[$];
  logic [31:0] m_pace;
  bit          m_en, m_ovf, m_udf, m_push;
  logic [15:0] m_adc;
  longint      cyc = 0;
  longint      next_ok = 0;

  logic [31:0] last_rdata;
  logic [15:0] strobe_val[$];
  longint      strobe_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_rdata();
    logic [31:0] r;
    int n;
    r = '0;
    n = q.size();
    if (bus.read) begin
      case (bus.addr[15:0])
        16'h0124: r = m_pace;
        16'h0128: r = {31'b0, m_en};
        16'h012C: r = {16'b0, 8'(n), 4'b0, m_udf, m_ovf, (n == DEPTH), (n == 0)};
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pace = 32'd1;
    m_en = 0; m_ovf = 0; m_udf = 0; m_push = 0;
    m_adc = '0;
    next_ok = cyc + 1;
  endtask

  task automatic model_update();
    bit ws, wp, wc, rs, fl, elig, popping, und, ovf_ev;
    if (rst) begin
      model_reset();
    end else begin
      ws = bus.write && (bus.addr[15:0] == 16'h0120);
      wp = bus.write && (bus.addr[15:0] == 16'h0124);
      wc = bus.write && (bus.addr[15:0] == 16'h0128);
      rs = bus.read  && (bus.addr[15:0] == 16'h012C);
      fl = wc && bus.Wdata[1];
      elig    = m_en && (cyc >= next_ok);
      popping = elig && (q.size() > 0);
      und     = elig && (q.size() == 0);
      ovf_ev  = ws && !fl && (q.size() == DEPTH) && !popping;
      m_push = 0;
      if (fl) begin
        q.delete();
        next_ok = cyc + 1;
      end else begin
        if (popping) begin
          m_adc = q.pop_front();
          m_push = 1;
          next_ok = cyc + ((m_pace == 0) ? 64'd1 : longint'(m_pace));
        end
        if (ws && q.size() < DEPTH) q.push_back(bus.Wdata[15:0]);
      end
      if (!m_en) next_ok = cyc + 1;
      m_ovf = ovf_ev || (m_ovf && !rs);
      m_udf = und || (m_udf && !rs);
      if (wp) m_pace = bus.Wdata;
      if (wc) m_en = bus.Wdata[0];
    end
    cyc++;
  endtask

  // One clock: inputs are already applied; read data checked mid-cycle, outputs after the edge.
  task automatic tick();
    @(negedge clk);
    last_rdata = bus.Rdata;
    if (!rst) check("rdata", bus.Rdata, m_rdata());
    model_update();
    @(posedge clk);
    #1;
    check("pushADC", {31'b0, pushADC}, {31'b0, m_push});
    check("ADC", {16'b0, ADC}, {16'b0, m_adc});
    check("level", 32'(level), 32'(q.size()));
    if (pushADC) begin
      strobe_val.push_back(ADC);
      strobe_cyc.push_back(cyc);
    end
  endtask

  task automatic bus_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    bus.write = w; bus.read = r; bus.addr = a; bus.Wdata = d;
    tick();
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d); bus_op(1, 0, a, d); endtask
  task automatic rd(input logic [31:0] a); bus_op(0, 1, a, '0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_op(0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    strobe_val.delete();
    strobe_cyc.delete();
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lvl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint w0;
    int r;
    bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.Wdata = '0;
    rst = 1'b1;

    // Register map in the idle (disabled) state.
    tbl.push_back('{0, 1, A_PACE,        32'h0,    32'h1,        0});
    tbl.push_back('{0, 1, A_CTRL,        32'h0,    32'h0,        0});
    tbl.push_back('{0, 1, A_STATUS,      32'h0,    32'h1,        0});
    tbl.push_back('{1, 0, A_PACE,        32'h7,    32'h0,        0});
    tbl.push_back('{0, 1, A_PACE,        32'h0,    32'h7,        0});
    tbl.push_back('{1, 0, A_SAMPLE,      32'h1234, 32'h0,        1});
    tbl.push_back('{0, 1, A_SAMPLE,      32'h0,    32'h0,        1});
    tbl.push_back('{0, 1, A_STATUS,      32'h0,    32'h0000_0100, 1});
    tbl.push_back('{0, 1, 32'h0130,      32'h0,    32'h0,        1});
    tbl.push_back('{0, 1, 32'hFFFF_0124, 32'h0,    32'h7,        1});
    tbl.push_back('{0, 1, 32'h0000_1124, 32'h0,    32'h0,        1});
    tbl.push_back('{1, 0, A_CTRL,        32'h2,    32'h0,        0});
    tbl.push_back('{0, 1, A_STATUS,      32'h0,    32'h1,        0});
    tbl.push_back('{0, 1, A_CTRL,        32'h0,    32'h0,        0});

    do_reset();
    check("reset_push", {31'b0, pushADC}, 32'h0);
    check("reset_level", 32'(level), 32'h0);
    foreach (tbl[i]) begin
      bus_op(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_rdata", i), last_rdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_lvl));
    end

    // PACE=3 paced stream, then underflow.
    do_reset();
    wr(A_PACE, 3); wr(A_CTRL, 1);
    w0 = cyc;
    wr(A_SAMPLE, 32'h1111); wr(A_SAMPLE, 32'h2222); wr(A_SAMPLE, 32'h3333);
    idle(15);
    check("t1_count", strobe_val.size(), 3);
    if (strobe_val.size() == 3) begin
      check("t1_latency", 32'(strobe_cyc[0] - w0), 2);
      check("t1_gap0", 32'(strobe_cyc[1] - strobe_cyc[0]), 3);
      check("t1_gap1", 32'(strobe_cyc[2] - strobe_cyc[1]), 3);
      check("t1_v0", strobe_val[0], 32'h1111);
      check("t1_v1", strobe_val[1], 32'h2222);
      check("t1_v2", strobe_val[2], 32'h3333);
    end
    rd(A_STATUS);
    check("t1_underflow", {31'b0, last_rdata[3]}, 32'h1);

    // PACE=0 acts as 1: back-to-back strobes.
    do_reset();
    wr(A_PACE, 0);
    for (int i = 0; i < 4; i++) wr(A_SAMPLE, 32'hC0 + i);
    wr(A_CTRL, 1);
    idle(8);
    check("t2_count", strobe_val.size(), 4);
    if (strobe_val.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("t2_gap", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 1);
        check("t2_val", strobe_val[i], 32'hC0 + i);
      end
    end
    rd(A_STATUS);
    check("t2_empty", {31'b0, last_rdata[0]}, 32'h1);

    // Overflow, clear-on-read, then a write coincident with a pop from a full FIFO.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) wr(A_SAMPLE, 32'hA000 + i);
    check("t3_level", 32'(level), 32'd16);
    rd(A_STATUS);
    check("t3_status", last_rdata, 32'h0000_1006);
    rd(A_STATUS);
    check("t3_status_clr", last_rdata, 32'h0000_1002);
    wr(A_PACE, 1);
    wr(A_CTRL, 1);
    wr(A_SAMPLE, 32'hBEEF);
    check("t4_level", 32'(level), 32'd16);
    rd(A_STATUS);
    check("t4_no_ovf", {31'b0, last_rdata[2]}, 32'h0);
    idle(25);
    check("t4_count", strobe_val.size(), 17);
    if (strobe_val.size() == 17) begin
      check("t4_first", strobe_val[0], 32'hA000);
      check("t4_last_old", strobe_val[15], 32'hA00F);
      check("t4_new", strobe_val[16], 32'hBEEF);
    end

    // Flush mid-stream.
    do_reset();
    wr(A_PACE, 4);
    for (int i = 0; i < 5; i++) wr(A_SAMPLE, 32'h50 + i);
    wr(A_CTRL, 1);
    idle(5);
    check("t5_pre", strobe_val.size(), 2);
    strobe_val.delete(); strobe_cyc.delete();
    wr(A_CTRL, 3);
    idle(10);
    check("t5_none", strobe_val.size(), 0);
    check("t5_level", 32'(level), 0);
    rd(A_STATUS);
    check("t5_status", last_rdata & 32'h0000_FF03, 32'h1);
    w0 = cyc;
    wr(A_SAMPLE, 32'h5A5A);
    idle(4);
    check("t5_count", strobe_val.size(), 1);
    if (strobe_val.size() == 1) begin
      check("t5_latency", 32'(strobe_cyc[0] - w0), 2);
      check("t5_val", strobe_val[0], 32'h5A5A);
    end

    // Reset mid-stream.
    do_reset();
    wr(A_PACE, 2);
    for (int i = 0; i < 3; i++) wr(A_SAMPLE, 32'h70 + i);
    wr(A_CTRL, 1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_push", {31'b0, pushADC}, 0);
    check("t6_adc", {16'b0, ADC}, 0);
    check("t6_level", 32'(level), 0);
    rd(A_PACE);
    check("t6_pace", last_rdata, 1);
    rd(A_CTRL);
    check("t6_ctrl", last_rdata, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40)       wr(A_SAMPLE, $urandom);
      else if (r < 46)  wr(A_PACE, $urandom_range(0, 4));
      else if (r < 54)  wr(A_CTRL, {30'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) != 0)});
      else if (r < 64)  rd(A_STATUS);
      else if (r < 70) begin
        case ($urandom_range(0, 4))
          0: rd(A_SAMPLE);
          1: rd(A_PACE);
          2: rd(A_CTRL);
          3: rd(32'h0130);
          default: rd(32'h0);
        endcase
      end
      else if (r < 71) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      else idle(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
